// File: rtl/conv_scheduler_s2_if.sv
// Handshake bundle between the stage-2 conv scheduler and its MAC engine,
// tensor builder and result writer.
interface conv_scheduler_s2_if #(
  parameter int ACC_W = 35
);
  logic             tensor_ready;
  logic             busy;
  logic [1:0]       filter_used;
  logic [2:0]       win_row;
  logic [2:0]       win_col;
  logic             mac_start;
  logic             mac_done;
  logic [ACC_W-1:0] mac_result;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_addr;
  logic [ACC_W-1:0] out_data;
  logic             frame_done;

  modport master (
    input  tensor_ready,
    input  mac_done,
    input  mac_result,
    input  out_ready,
    output busy,
    output filter_used,
    output win_row,
    output win_col,
    output mac_start,
    output out_valid,
    output out_addr,
    output out_data,
    output frame_done
  );

  modport slave (
    output tensor_ready,
    output mac_done,
    output mac_result,
    output out_ready,
    input  busy,
    input  filter_used,
    input  win_row,
    input  win_col,
    input  mac_start,
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  frame_done
  );
endinterface

// File: rtl/conv_scheduler_s2.sv
// Stage-2 conv sequencer: walks 4 filters x 6x6 windows, fires the MAC
// and streams each result to the writer over valid/ready.
module conv_scheduler_s2 #(
  parameter int N_FILT  = 4,
  parameter int OUT_DIM = 6,
  parameter int ACC_W   = 35
) (
  input  logic clk,
  input  logic reset,
  conv_scheduler_s2_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] F_LAST = 2'(N_FILT - 1);
  localparam logic [2:0] D_LAST = 3'(OUT_DIM - 1);
  localparam logic [7:0] ROW_SZ = 8'(OUT_DIM);
  localparam logic [7:0] FLT_SZ = 8'(OUT_DIM * OUT_DIM);

  state_t           state;
  logic [1:0]       f;
  logic [2:0]       r;
  logic [2:0]       c;
  logic             busy;
  logic             mac_start;
  logic             out_valid;
  logic             frame_done;
  logic [7:0]       addr;
  logic [ACC_W-1:0] data;
  logic             last;
  logic [7:0]       idx;

  assign last = (f == F_LAST) && (r == D_LAST) && (c == D_LAST);
  assign idx  = 8'(f) * FLT_SZ + 8'(r) * ROW_SZ + 8'(c);

  assign bus.busy        = busy;
  assign bus.filter_used = f;
  assign bus.win_row     = r;
  assign bus.win_col     = c;
  assign bus.mac_start   = mac_start;
  assign bus.out_valid   = out_valid;
  assign bus.out_addr    = addr;
  assign bus.out_data    = data;
  assign bus.frame_done  = frame_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      f          <= '0;
      r          <= '0;
      c          <= '0;
      busy       <= 1'b0;
      mac_start  <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      addr       <= '0;
      data       <= '0;
    end else begin
      mac_start  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tensor_ready) begin
            f         <= '0;
            r         <= '0;
            c         <= '0;
            busy      <= 1'b1;
            mac_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.mac_done) begin
            data      <= bus.mac_result;
            addr      <= idx;
            out_valid <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              // column fastest, then row, then filter
              if (c == D_LAST) begin
                c <= '0;
                if (r == D_LAST) begin
                  r <= '0;
                  f <= f + 2'd1;
                end else begin
                  r <= r + 3'd1;
                end
              end else begin
                c <= c + 3'd1;
              end
              mac_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_scheduler_s2.md
# conv_scheduler_s2

Sequencer for the stage-2 convolution datapath. It starts once the stage-2 input tensor (8x8x3) is fully loaded and walks every filter/window combination: 4 filters x 6x6 window positions. For each combination it selects the filter, sets the window position, fires the MAC engine and hands the 144 results to the output writer in order over a valid/ready handshake. It sits between the tensor builder/filter mux and the stage-2 result buffer.

## Interface
Parameters:
- N_FILT, 4, number of 3x3x3 filters in the filter ROM
- OUT_DIM, 6, output rows/cols per filter (8 - 3 + 1)
- ACC_W, 35, width of one MAC result

Ports:
- clk  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- tensor_ready  in  1  one-cycle pulse: input tensor complete and stable
- busy  out  1  high from frame acceptance until the frame_done cycle inclusive
- filter_used  out  2  filter select to the channel mux
- win_row  out  3  top-left row of the 3x3 window, 0..5
- win_col  out  3  top-left col of the 3x3 window, 0..5
- mac_start  out  1  one-cycle pulse: begin MAC on the current filter/window
- mac_done  in  1  one-cycle pulse from the MAC engine; result valid this cycle
- mac_result  in  ACC_W  MAC result, sampled when mac_done=1
- out_valid  out  1  out_addr/out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_addr  out  8  result index = filter*36 + row*6 + col, 0..143
- out_data  out  ACC_W  registered MAC result
- frame_done  out  1  one-cycle pulse after the 144th result is accepted

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: tensor_ready=1 -> clear counters (f=r=c=0), busy=1, go to ISSUE. tensor_ready is ignored in every other state.
- ISSUE: mac_start=1 for exactly this cycle. Go to WAIT.
- WAIT: hold until mac_done=1. On mac_done, register mac_result into out_data and set out_addr from the counters, then go to WRITE.
- WRITE: out_valid=1. out_addr and out_data are held while out_ready=0. On the handshake:
  - if last (f=3, r=5, c=5), go to DONE;
  - otherwise advance the counters and go to ISSUE.
- Counter order: c fastest, then r, then f. On c=5, c wraps to 0 and r increments. On r=5 & c=5, both wrap and f increments.
- filter_used, win_row and win_col are driven directly from f, r, c. They are stable from ISSUE through the WRITE handshake.
- DONE: frame_done=1 and busy=1 for one cycle, then IDLE with busy=0.
- mac_done is sampled only in WAIT. A mac_done in IDLE, ISSUE, WRITE or DONE is dropped and causes no state change.
- out_addr arithmetic is done in 8 bits with no overflow; the maximum value is 143.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE;
  - busy, mac_start, out_valid and frame_done are 0;
  - filter_used, win_row, win_col, out_addr and out_data are 0.
- Reset mid-frame aborts immediately. No frame_done is issued. The first tensor_ready after reset release starts a new frame from index 0.
- tensor_ready to first mac_start: 1 cycle (IDLE->ISSUE edge, then mac_start in the ISSUE cycle).
- Per result: 1 (ISSUE) + L_mac (cycles from mac_start to mac_done, >=1) + W (>=1, WRITE cycles until handshake).
- Minimum frame with L_mac=1 and out_ready tied 1: 144 x 3 = 432 cycles from the first ISSUE to the last handshake. frame_done follows 1 cycle later.
- out_valid rises the cycle after mac_done. It falls in the cycle after the handshake, and never stays high across two results.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Full frame: MAC model with L_mac=1 returning mac_result=out index, out_ready=1 -> 144 handshakes with out_addr=out_data=0..143 in order, frame_done 433 cycles after the first mac_start, then busy=0.
- Scan order: capture the state at out_addr=37 -> filter_used=1, win_row=0, win_col=1. At out_addr=143 -> 3/5/5. At out_addr=36 -> 1/0/0.
- Backpressure: drop out_ready for 5 cycles at index 10 -> out_valid held, out_addr=10 and out_data stable, no mac_start during the stall, index 11 issued after the handshake.
- Spurious inputs: tensor_ready pulsed at index 50 and mac_done pulsed in a WRITE cycle -> no restart, no extra output, count stays 144.
- Reset mid-frame: assert reset at index 70 -> all outputs 0 immediately. A new tensor_ready then gives a clean frame starting at out_addr=0 with exactly one frame_done.
- Variable latency: random L_mac in 1..8 with random out_ready -> 144 ordered results, each out_data equal to its mac_result, exactly one frame_done.
